batch_sequencer: RTL

//  Central sequencer for the batch-mode control-bounded filter. It generates the

---
 rtl/batch_pkg.sv | 27 ++
 rtl/batch_addr_counter.sv | 50 +++++
 rtl/batch_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/batch_pkg.sv
// batch_pkg
//   Shared types and helpers for the batch-mode filter sequencer.
//   bank_t       : 2-bit index into the 4-bank sample RAM
//   seq_state_e  : sequencer FSM state (IDLE / FILL / RUN)
//   NUM_BANKS    : number of sample-RAM banks in the rotation
//   bank_add()   : bank index arithmetic modulo NUM_BANKS
package batch_pkg;

  typedef logic [1:0] bank_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

  localparam int NUM_BANKS = 4;

  // Modulo-4 add; negative k works because only the low two bits of the
  // two's-complement sum are kept.
  function automatic bank_t bank_add(bank_t b, int k);
    int s;
    s = int'(b) + k;
    return bank_t'(s[1:0]);
  endfunction

endpackage

// File: rtl/batch_addr_counter.sv
// batch_addr_counter
//   Batch address generator: counts 0..DEPTH-1 on each advance and wraps
//   with an explicit compare, so DEPTH need not be a power of two.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     adv       : advance strobe; the counter holds when low
//     addr_fwd  : forward address
//     addr_rev  : reverse address, DEPTH-1-addr_fwd
//     wrap      : combinational pulse on an advance at the last address
//                 (suppressed while rst is high)
module batch_addr_counter #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [AW-1:0] addr_fwd,
  output logic [AW-1:0] addr_rev,
  output logic          wrap
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic          at_last;

  assign at_last = (addr_q == LAST);

  always_comb begin
    addr_d = addr_q;
    if (adv) begin
      addr_d = at_last ? '0 : addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_fwd = addr_q;
  assign addr_rev = LAST - addr_q;
  assign wrap     = adv & ~rst & at_last;

endmodule

// File: rtl/batch_sequencer.sv
// batch_sequencer
//   Central sequencer for the batch-mode control-bounded filter: batch
//   addresses, 4-bank sample-RAM rotation, part-result ping-pong select,
//   recursion reload pulse and output-valid.
//   Build option: define BATCH_SEQ_STALL_EN to make every state element
//   advance only on in_valid; otherwise everything advances every clock and
//   in_valid is ignored.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     in_valid   : sample strobe (stall build only)
//     addr_fwd   : forward batch address      addr_rev : DEPTH-1-addr_fwd
//     bank_wr    : one-hot sample-RAM write enable for the current cycle
//     bank_lh    : lookahead bank   bank_cb : backward-compute bank
//     bank_cf    : forward-compute bank (bank_cb delayed one advance)
//     part_sel   : part-result RAM ping-pong select (cycle bit 0)
//     rec_rst    : 1-clk recursion reload pulse (same as batch_end)
//     batch_end  : 1-clk pulse on the last address of a batch
//     out_valid  : filter output valid (registered)
//     state      : current FSM state
module batch_sequencer
  import batch_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int FILL_BATCHES = 3,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic [AW-1:0]        addr_fwd,
  output logic [AW-1:0]        addr_rev,
  output logic [NUM_BANKS-1:0] bank_wr,
  output logic [1:0]           bank_lh,
  output logic [1:0]           bank_cf,
  output logic [1:0]           bank_cb,
  output logic                 part_sel,
  output logic                 rec_rst,
  output logic                 batch_end,
  output logic                 out_valid,
  output seq_state_e           state
);

  localparam int              FW        = $clog2(FILL_BATCHES + 1);
  localparam logic [FW-1:0]   FILL_MAX  = FW'(FILL_BATCHES);
  localparam logic [FW-1:0]   FILL_LAST = FW'(FILL_BATCHES - 1);

  logic adv;

`ifdef BATCH_SEQ_STALL_EN
  assign adv = in_valid;
`else
  // in_valid stays on the port so both builds share one interface.
  logic unused_in_valid;
  assign unused_in_valid = in_valid;
  assign adv = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // Address counter
  // ---------------------------------------------------------------------
  logic wrap;

  batch_addr_counter #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .adv      (adv),
    .addr_fwd (addr_fwd),
    .addr_rev (addr_rev),
    .wrap     (wrap)
  );

  assign batch_end = wrap;
  assign rec_rst   = wrap;

  // ---------------------------------------------------------------------
  // Bank rotation
  // ---------------------------------------------------------------------
  bank_t cycle_q,   cycle_d;
  bank_t bank_cf_q, bank_cf_d;
  bank_t bank_cb_w;

  assign bank_cb_w = bank_add(cycle_q, 1);

  always_comb begin
    cycle_d   = cycle_q;
    bank_cf_d = bank_cf_q;
    if (adv) begin
      // Forward compute reads the bank that backward compute used on the
      // previous advance, matching the one-sample pipe ahead of it.
      bank_cf_d = bank_cb_w;
      if (wrap) begin
        cycle_d = bank_add(cycle_q, 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 2'd0;
      bank_cf_q <= 2'd1;
    end else begin
      cycle_q   <= cycle_d;
      bank_cf_q <= bank_cf_d;
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_wr
    assign bank_wr[gi] = (cycle_q == bank_t'(gi));
  end

  assign bank_lh  = bank_add(cycle_q, -1);
  assign bank_cb  = bank_cb_w;
  assign bank_cf  = bank_cf_q;
  assign part_sel = cycle_q[0];

  // ---------------------------------------------------------------------
  // Fill / run FSM
  // ---------------------------------------------------------------------
  seq_state_e    state_q,     state_d;
  logic [FW-1:0] fill_cnt_q,  fill_cnt_d;
  logic          out_valid_q, out_valid_d;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    if (adv) begin
      case (state_q)
        IDLE: state_d = FILL;
        FILL: begin
          if (wrap) begin
            if (fill_cnt_q != FILL_MAX) begin
              fill_cnt_d = fill_cnt_q + 1'b1;
            end
            if (fill_cnt_q == FILL_LAST) begin
              state_d = RUN;
            end
          end
        end
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
    // Registered from the next state so it rises on the same edge that
    // enters RUN.
    out_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign state     = state_q;
  assign out_valid = out_valid_q;

endmodule
